// File: rtl/router_pkg.sv
// Shared widths, header layout and transmit FSM states for the router packet source.
package router_pkg;

  localparam int DEF_DATA_W   = 8;
  localparam int DEF_LEN_W    = 6;
  localparam int DEF_ADDR_W   = 2;
  localparam int DEF_FIFO_D   = 64;
  localparam int DEF_ERR_WAIT = 3;

  localparam int HDR_DEST_LSB = 0;
  localparam int HDR_LEN_LSB  = DEF_ADDR_W;

  localparam int ILLEGAL_DEST = 3;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_HEADER  = 3'd1,
    ST_PAYLOAD = 3'd2,
    ST_PARITY  = 3'd3,
    ST_ERRWAIT = 3'd4
  } tx_state_t;

endpackage

// File: rtl/router_pkt_tx_if.sv
// Byte stream between the packet source (master) and the router input port (slave).
interface router_pkt_tx_if #(
  parameter int DATA_W = router_pkg::DEF_DATA_W
) ();

  logic              pkt_valid;
  logic [DATA_W-1:0] data_out;
  logic              busy;
  logic              err;

  modport master (output pkt_valid, data_out, input busy, err);
  modport slave  (input pkt_valid, data_out, output busy, err);

endinterface

// File: rtl/router_tx_fifo.sv
// Synchronous payload FIFO with first-word fall-through head and occupancy count.
module router_tx_fifo #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 64
) (
  input  logic                       clock,
  input  logic                       resetn,
  input  logic                       wr_en,
  input  logic [DATA_W-1:0]          wr_data,
  input  logic                       rd_en,
  output logic [DATA_W-1:0]          head,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       full
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [CNT_W-1:0]  count_q;
  logic [CNT_W-1:0]  count_n;
  logic              full_q;
  logic              push;
  logic              pop;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // A full buffer drops writes even when a pop happens in the same cycle.
  assign push = wr_en && !full_q;
  assign pop  = rd_en && (count_q != '0);

  always_ff @(posedge clock) begin
    if (push) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  always_comb begin
    count_n = count_q;
    if (push && !pop) begin
      count_n = count_q + CNT_W'(1);
    end else if (!push && pop) begin
      count_n = count_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
      full_q  <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= next_ptr(wr_ptr);
      end
      if (pop) begin
        rd_ptr <= next_ptr(rd_ptr);
      end
      count_q <= count_n;
      full_q  <= (count_n == CNT_W'(DEPTH));
    end
  end

  assign head  = mem[rd_ptr];
  assign count = count_q;
  assign full  = full_q;

endmodule

// File: rtl/router_pkt_tx.sv
// Router packet source: sends header, buffered payload and XOR parity, then samples router err.
module router_pkt_tx
  import router_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int LEN_W    = DEF_LEN_W,
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int FIFO_D   = DEF_FIFO_D,
  parameter int ERR_WAIT = DEF_ERR_WAIT
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  output logic              buf_full,
  input  logic              start,
  input  logic [ADDR_W-1:0] dest,
  input  logic [LEN_W-1:0]  len,
  output logic              req_ready,
  router_pkt_tx_if.master   tx,
  output logic              done,
  output logic              err_flag,
  output logic              bad_req
);

  localparam int CNT_W  = $clog2(FIFO_D + 1);
  localparam int WAIT_W = (ERR_WAIT > 1) ? $clog2(ERR_WAIT) : 1;

  tx_state_t         state_q, state_n;
  logic [DATA_W-1:0] data_q, data_n;
  logic [DATA_W-1:0] parity_q, parity_n;
  logic [LEN_W-1:0]  rem_q, rem_n;
  logic [WAIT_W-1:0] wait_q, wait_n;
  logic              valid_q, valid_n;
  logic              err_flag_q, err_flag_n;
  logic              ready_q, ready_n;
  logic              done_q, done_n;
  logic              bad_q, bad_n;
  logic              pop;
  logic [DATA_W-1:0] fifo_head;
  logic [CNT_W-1:0]  fifo_count;

  router_tx_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (FIFO_D)
  ) u_fifo (
    .clock   (clock),
    .resetn  (resetn),
    .wr_en   (wr_en),
    .wr_data (wr_data),
    .rd_en   (pop),
    .head    (fifo_head),
    .count   (fifo_count),
    .full    (buf_full)
  );

  // The byte on data_out is popped from the buffer when it is loaded, so a
  // stall simply holds the output register and never consumes another byte.
  always_comb begin
    state_n    = state_q;
    data_n     = data_q;
    parity_n   = parity_q;
    rem_n      = rem_q;
    wait_n     = wait_q;
    valid_n    = valid_q;
    err_flag_n = err_flag_q;
    ready_n    = ready_q;
    done_n     = 1'b0;
    bad_n      = 1'b0;
    pop        = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          if ((len == '0) || (dest == ADDR_W'(ILLEGAL_DEST)) ||
              (fifo_count < CNT_W'(len))) begin
            bad_n = 1'b1;
          end else begin
            data_n = '0;
            data_n[HDR_LEN_LSB +: LEN_W]   = len;
            data_n[HDR_DEST_LSB +: ADDR_W] = dest;
            rem_n      = len;
            valid_n    = 1'b1;
            err_flag_n = 1'b0;
            ready_n    = 1'b0;
            state_n    = ST_HEADER;
          end
        end
      end

      ST_HEADER: begin
        if (!tx.busy) begin
          parity_n = data_q;
          data_n   = fifo_head;
          pop      = 1'b1;
          state_n  = ST_PAYLOAD;
        end
      end

      ST_PAYLOAD: begin
        if (!tx.busy) begin
          parity_n = parity_q ^ data_q;
          if (rem_q == LEN_W'(1)) begin
            data_n  = parity_q ^ data_q;
            valid_n = 1'b0;
            state_n = ST_PARITY;
          end else begin
            data_n = fifo_head;
            pop    = 1'b1;
            rem_n  = rem_q - LEN_W'(1);
          end
        end
      end

      ST_PARITY: begin
        if (!tx.busy) begin
          data_n  = '0;
          wait_n  = '0;
          state_n = ST_ERRWAIT;
        end
      end

      ST_ERRWAIT: begin
        err_flag_n = err_flag_q | tx.err;
        if (wait_q == WAIT_W'(ERR_WAIT - 1)) begin
          done_n  = 1'b1;
          ready_n = 1'b1;
          state_n = ST_IDLE;
        end else begin
          wait_n = wait_q + WAIT_W'(1);
        end
      end

      default: begin
        state_n = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q    <= ST_IDLE;
      data_q     <= '0;
      parity_q   <= '0;
      rem_q      <= '0;
      wait_q     <= '0;
      valid_q    <= 1'b0;
      err_flag_q <= 1'b0;
      ready_q    <= 1'b1;
      done_q     <= 1'b0;
      bad_q      <= 1'b0;
    end else begin
      state_q    <= state_n;
      data_q     <= data_n;
      parity_q   <= parity_n;
      rem_q      <= rem_n;
      wait_q     <= wait_n;
      valid_q    <= valid_n;
      err_flag_q <= err_flag_n;
      ready_q    <= ready_n;
      done_q     <= done_n;
      bad_q      <= bad_n;
    end
  end

  assign tx.pkt_valid = valid_q;
  assign tx.data_out  = data_q;
  assign req_ready    = ready_q;
  assign done         = done_q;
  assign err_flag     = err_flag_q;
  assign bad_req      = bad_q;

endmodule
